// File: rtl/nibble_add_sched_pkg.sv
// nibble_add_pkg: shared constants and state type for the nibble-serial add scheduler
package nibble_add_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {IDLE, ADD, DONE} nibble_add_state_t;
endpackage

// File: rtl/nibble_add_sched_if.sv
// nibble_add_sched_if: requester/result bundle; res_ovf exists only with NIBBLE_ADD_OVF_EN
interface nibble_add_sched_if import nibble_add_pkg::*; #(parameter int NIBBLES = 4);
    localparam int W = NIBBLE_W * NIBBLES;
    logic         req0_valid, req0_cin, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_cin, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic         res_valid, res_ready, res_cout, res_id, busy;
    logic [W-1:0] res_sum;
`ifdef NIBBLE_ADD_OVF_EN
    logic         res_ovf;
`endif
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin, req1_valid, req1_a, req1_b, req1_cin, res_ready,
        input  req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, busy
`ifdef NIBBLE_ADD_OVF_EN
        , res_ovf
`endif
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin, req1_valid, req1_a, req1_b, req1_cin, res_ready,
        output req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id, busy
`ifdef NIBBLE_ADD_OVF_EN
        , res_ovf
`endif
    );
endinterface

// File: rtl/nibble_add_sched_adder.sv
// four_bit_full_adder: the single shared 4-bit ripple datapath
module four_bit_full_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4
);
    assign {c4, s} = {1'b0, a} + {1'b0, b} + {4'b0, c0};
endmodule

// File: rtl/nibble_add_sched.sv
// nibble_add_sched: round-robin two-requester scheduler over one 4-bit adder; NIBBLE_ADD_OVF_EN adds res_ovf
module nibble_add_sched import nibble_add_pkg::*; #(
    parameter int NIBBLES = 4
) (
    input logic clk,
    input logic rst,
    nibble_add_sched_if.slave bus
);
    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    nibble_add_state_t   r_state;
    logic [W-1:0]        r_a, r_b, r_sum;
    logic [IW-1:0]       r_idx;
    logic                r_carry, r_ptr, r_id, r_valid;
    logic                w_gnt, w_rdy0, w_rdy1, w_c4;
    logic [NIBBLE_W-1:0] w_na, w_nb, w_s;
`ifdef NIBBLE_ADD_OVF_EN
    logic                r_ovf;
    assign bus.res_ovf = r_ovf;
`endif
    assign w_gnt  = (bus.req0_valid & bus.req1_valid) ? r_ptr : bus.req1_valid;
    assign w_rdy0 = (r_state == IDLE) & bus.req0_valid & ~w_gnt;
    assign w_rdy1 = (r_state == IDLE) & bus.req1_valid & w_gnt;
    assign w_na   = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_nb   = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.res_valid  = r_valid;
    assign bus.res_sum    = r_sum;
    assign bus.res_cout   = r_carry;
    assign bus.res_id     = r_id;
    assign bus.busy       = r_state != IDLE;
    four_bit_full_adder u_add (.a(w_na), .b(w_nb), .c0(r_carry), .s(w_s), .c4(w_c4));
    // accept -> ripple one nibble per cycle -> hold result until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_ptr   <= 1'b0;
            r_id    <= 1'b0;
            r_valid <= 1'b0;
`ifdef NIBBLE_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_rdy0 | w_rdy1) begin
                    r_a     <= w_gnt ? bus.req1_a : bus.req0_a;
                    r_b     <= w_gnt ? bus.req1_b : bus.req0_b;
                    r_carry <= w_gnt ? bus.req1_cin : bus.req0_cin;
                    r_id    <= w_gnt;
                    r_idx   <= '0;
                    r_state <= ADD;
                end
                ADD: begin
                    r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_s;
                    r_carry <= w_c4;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == IW'(NIBBLES - 1)) begin
                        r_valid <= 1'b1;
                        r_state <= DONE;
`ifdef NIBBLE_ADD_OVF_EN
                        r_ovf   <= (w_na[3] ^ w_nb[3] ^ w_s[3]) ^ w_c4;
`endif
                    end
                end
                DONE: if (bus.res_ready) begin
                    r_valid <= 1'b0;
                    r_ptr   <= ~r_id;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
